// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI-Lite interconnect.
package axil_pkg;

    localparam int NUMBER_MASTER = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } axil_wr_arb_state_t;

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin picker: finds the first request at or after
// ptr+1, wrapping modulo N. Shared by the read and write arbiters.
module axil_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    logic [W-1:0] start;
    logic [W-1:0] cand [N];
    logic [N-1:0] hit;

    // The explicit compare against N-1 keeps the wrap correct for non-power-of-two N.
    assign start = (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [W:0] sum;
        assign sum        = {1'b0, start} + (W + 1)'(gi);
        assign cand[gi]   = (sum > (W + 1)'(N - 1)) ? W'(sum - (W + 1)'(N)) : sum[W-1:0];
        assign hit[gi]    = req[cand[gi]];
    end

    // Lowest search offset with a request wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

    assign onehot = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/axil_arbiter_rr_wr.sv
// Per-slave write-channel round-robin arbiter. Grants one master, then
// holds the grant through the AW, W and B handshakes of that path.
module axil_arbiter_rr_wr #(
    parameter int NUMBER_MASTER = axil_pkg::NUMBER_MASTER,
    parameter int W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUMBER_MASTER-1:0] req_wr,
    output logic [NUMBER_MASTER-1:0] grant_wr,
    output logic [W-1:0]             grant_idx,
    output logic                     busy,
    input  logic                     s_awvalid,
    input  logic                     s_awready,
    input  logic                     s_wvalid,
    input  logic                     s_wready,
    input  logic                     s_bvalid,
    input  logic                     s_bready
);

    import axil_pkg::*;

    axil_wr_arb_state_t     state_reg;
    logic                   aw_done_reg;
    logic                   w_done_reg;
    logic [W-1:0]           rr_ptr_reg;

    logic                   pick_valid;
    logic [W-1:0]           pick_idx;
    logic [NUMBER_MASTER-1:0] pick_onehot;

    logic aw_hs, w_hs, b_hs;
    logic aw_now, w_now;

    assign aw_hs  = s_awvalid & s_awready;
    assign w_hs   = s_wvalid  & s_wready;
    assign b_hs   = s_bvalid  & s_bready;
    assign aw_now = aw_done_reg | aw_hs;
    assign w_now  = w_done_reg  | w_hs;

    axil_rr_pick #(
        .N (NUMBER_MASTER),
        .W (W)
    ) u_pick (
        .req    (req_wr),
        .ptr    (rr_ptr_reg),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // FSM, handshake flags, round-robin pointer and grant registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg   <= IDLE;
            grant_wr    <= '0;
            grant_idx   <= '0;
            busy        <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rr_ptr_reg  <= W'(NUMBER_MASTER - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_wr  <= pick_onehot;
                        grant_idx <= pick_idx;
                        busy      <= 1'b1;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    aw_done_reg <= aw_now;
                    w_done_reg  <= w_now;
                    if (aw_now && w_now) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        state_reg   <= IDLE;
                        grant_wr    <= '0;
                        grant_idx   <= '0;
                        busy        <= 1'b0;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        rr_ptr_reg  <= grant_idx;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
